// File: rtl/load_store_unit.sv
// load_store_unit
//   Turns one pipeline load/store request into data-memory accesses and a
//   single-cycle completion pulse. Byte and halfword stores are handled as a
//   read-modify-write on the containing 32-bit word; loads are lane-selected
//   and sign/zero-extended.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (see below)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned      loads: 1 = zero-extend, 0 = sign-extend
//   req_addr          byte address
//   req_wdata         store data, right-aligned
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores, errors and when idle)
//   resp_err          misaligned / illegal size / out-of-range access
//   mem_addr          word-aligned address to data memory
//   mem_wdata         full word to data memory, little-endian lanes
//   mem_rdata         word from data memory, combinational on mem_addr
//   mem_w, mem_r      memory write / read strobes
//   dbg_state         current FSM state (IDLE=0, READ=1, WRITE=2, RESP=3)
//
// Handshake: a request transfers on a posedge where req_valid and req_ready
// are both 1. req_ready is high only in IDLE (and never while rst_n is low).
// All req_* fields are registered at that edge; the requester may change
// them freely afterwards. Completion is reported by exactly one resp_valid
// cycle; there is no back-pressure on the response side.
module load_store_unit #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_w,
  output logic        mem_r,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state_q, state_d;
  logic        accept;

  // Registered request
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] word_q;   // word captured at the end of READ

  // Acceptance-time error detection
  logic [2:0]  req_bytes;
  logic        req_misaligned;
  logic [32:0] req_end;  // one bit wider so addresses near 2^32 cannot wrap
  logic        req_err;

  // Datapath helpers
  logic [4:0]  lane_shift;
  logic [31:0] lane_mask;
  logic [31:0] lane_ins;
  logic [31:0] merged_word;
  logic [31:0] shifted_word;
  logic [31:0] load_data;

  assign accept = req_valid && req_ready;

  always_comb begin
    req_bytes      = 3'd0;
    req_misaligned = 1'b0;
    case (req_size)
      SZ_BYTE: req_bytes = 3'd1;
      SZ_HALF: begin
        req_bytes      = 3'd2;
        req_misaligned = req_addr[0];
      end
      SZ_WORD: begin
        req_bytes      = 3'd4;
        req_misaligned = |req_addr[1:0];
      end
      default: req_bytes = 3'd0;
    endcase
    req_end = {1'b0, req_addr} + {30'd0, req_bytes};
    req_err = (req_size == 2'b11) || req_misaligned || (req_end > MEM_LIMIT);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                 state_d = RESP;
          else if (!req_we)            state_d = READ;
          else if (req_size == SZ_WORD) state_d = WRITE;
          else                         state_d = READ;  // sub-word store: RMW
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      word_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
      if (state_q == READ) begin
        word_q <= mem_rdata;
      end
    end
  end

  // Lane selection shared by the store merge and the load extraction.
  // Halfword accesses are 2-byte aligned, so addr[0] is 0 and the byte shift
  // also selects the correct half lane.
  always_comb begin
    lane_shift = {addr_q[1:0], 3'b000};
    lane_mask  = 32'hFFFF_FFFF;
    lane_ins   = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        lane_mask = 32'h0000_00FF << lane_shift;
        lane_ins  = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        lane_mask = 32'h0000_FFFF << lane_shift;
        lane_ins  = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        lane_ins  = wdata_q;
      end
    endcase
    // Word stores never enter READ; the all-ones mask discards word_q.
    merged_word  = (word_q & ~lane_mask) | (lane_ins & lane_mask);

    shifted_word = word_q >> lane_shift;
    case (size_q)
      SZ_BYTE: load_data = uns_q ? {24'd0, shifted_word[7:0]}
                                 : {{24{shifted_word[7]}}, shifted_word[7:0]};
      SZ_HALF: load_data = uns_q ? {16'd0, shifted_word[15:0]}
                                 : {{16{shifted_word[15]}}, shifted_word[15:0]};
      default: load_data = word_q;
    endcase
  end

  // Outputs are decoded from the state register only, so an asynchronous
  // reset drops every strobe in the same cycle.
  always_comb begin
    req_ready  = rst_n && (state_q == IDLE);
    mem_r      = (state_q == READ);
    mem_w      = (state_q == WRITE);
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = 32'd0;
    if (state_q == READ || state_q == WRITE) begin
      mem_addr = {addr_q[31:2], 2'b00};
    end
    if (state_q == WRITE) begin
      mem_wdata = merged_word;
    end
    if (state_q == RESP && !err_q && !we_q) begin
      resp_rdata = load_data;
    end
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_w;
  logic        mem_r;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_w        (mem_w),
    .mem_r        (mem_r),
    .dbg_state    (dbg_state)
  );

  // ---------------- memory model and strobe monitor ----------------
  logic [31:0] tb_mem [0:63];
  int          mem_r_cnt = 0;
  int          mem_w_cnt = 0;
  int          resp_cnt  = 0;
  logic [31:0] last_wdata = 32'd0;

  assign mem_rdata = tb_mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_w) begin
      tb_mem[mem_addr[7:2]] <= mem_wdata;
      last_wdata            <= mem_wdata;
      mem_w_cnt             <= mem_w_cnt + 1;
    end
    if (mem_r)      mem_r_cnt <= mem_r_cnt + 1;
    if (resp_valid) resp_cnt  <= resp_cnt + 1;
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // ---------------- driver ----------------
  // Issues one request from IDLE, then measures the number of posedges from
  // the accepting edge (counted as 1) until resp_valid is seen.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int nr, output int nw);
    int r0, w0;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    r0 = mem_r_cnt; w0 = mem_w_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;  // fields must be ignored after acceptance
    req_wdata = 32'h5555_5555;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    nr    = mem_r_cnt - r0;
    nw    = mem_w_cnt - w0;
    @(posedge clk); #1;
    chk("pulse_end_valid", 32'(resp_valid), 32'd0);
    chk("pulse_end_rdata", resp_rdata, 32'd0);
  endtask

  task automatic expect_access(input string tag, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_nr, input int exp_nw);
    int lat, nr, nw;
    logic [31:0] rd;
    logic er;
    access(we, size, uns, addr, wdata, lat, rd, er, nr, nw);
    chk({tag, ".lat"},   lat, exp_lat);
    chk({tag, ".rdata"}, rd, exp_rdata);
    chk({tag, ".err"},   32'(er), 32'(exp_err));
    chk({tag, ".nr"},    nr, exp_nr);
    chk({tag, ".nw"},    nw, exp_nw);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] bb_addr [3] = '{32'h30, 32'h34, 32'h38};
  logic [31:0] bb_data [3] = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303};

  initial begin
    int acc [3];
    int n, w0, rsp0;
    logic rdy;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    // reset state
    #2;
    chk("rst.req_ready",  32'(req_ready),  32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.mem_r",      32'(mem_r),      32'd0);
    chk("rst.mem_w",      32'(mem_w),      32'd0);
    chk("rst.state",      32'(dbg_state),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel.req_ready", 32'(req_ready), 32'd1);

    // stores: word, then byte RMW over it
    expect_access("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 2, 32'd0, 1'b0, 0, 1);
    chk("mem10_a", tb_mem[4], 32'h1122_3344);
    expect_access("st_b11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAB, 3, 32'd0, 1'b0, 1, 1);
    chk("st_b11.wdata", last_wdata, 32'h1122_AB44);
    chk("mem10_b", tb_mem[4], 32'h1122_AB44);

    // loads over 0x80FF_7F01
    expect_access("st_w10b", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF_7F01, 2, 32'd0, 1'b0, 0, 1);
    expect_access("ld_b13s", 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 2, 32'hFFFF_FF80, 1'b0, 1, 0);
    expect_access("ld_b13u", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 2, 32'h0000_0080, 1'b0, 1, 0);
    expect_access("ld_h12s", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 2, 32'hFFFF_80FF, 1'b0, 1, 0);
    expect_access("ld_h10u", 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 2, 32'h0000_7F01, 1'b0, 1, 0);
    expect_access("ld_w10",  1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 2, 32'h80FF_7F01, 1'b0, 1, 0);
    expect_access("ld_b11s", 1'b0, 2'b00, 1'b0, 32'h11, 32'd0, 2, 32'h0000_007F, 1'b0, 1, 0);

    // halfword RMW store into the upper lane
    expect_access("st_h12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_BEEF, 3, 32'd0, 1'b0, 1, 1);
    chk("st_h12.wdata", last_wdata, 32'hBEEF_7F01);

    // top of memory: last legal byte
    expect_access("st_wFC", 1'b1, 2'b10, 1'b0, 32'hFC, 32'hA500_0000, 2, 32'd0, 1'b0, 0, 1);
    expect_access("ld_bFF", 1'b0, 2'b00, 1'b1, 32'hFF, 32'd0, 2, 32'h0000_00A5, 1'b0, 1, 0);

    // errors: no strobes, response one cycle after accept
    expect_access("err_w02",  1'b0, 2'b10, 1'b0, 32'h02,  32'd0, 1, 32'd0, 1'b1, 0, 0);
    expect_access("err_h05",  1'b0, 2'b01, 1'b0, 32'h05,  32'd0, 1, 32'd0, 1'b1, 0, 0);
    expect_access("err_sz11", 1'b0, 2'b11, 1'b0, 32'h00,  32'd0, 1, 32'd0, 1'b1, 0, 0);
    expect_access("err_wFE",  1'b0, 2'b10, 1'b0, 32'hFE,  32'd0, 1, 32'd0, 1'b1, 0, 0);
    expect_access("err_st100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h1234_5678, 1, 32'd0, 1'b1, 0, 0);
    chk("mem10_after_err", tb_mem[4], 32'hBEEF_7F01);

    // reset during WRITE of a byte store
    expect_access("st_w20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 2, 32'd0, 1'b0, 0, 1);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h0000_005A; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstw.state_read", 32'(dbg_state), 32'd1);
    @(posedge clk); #1;
    chk("rstw.mem_w_high", 32'(mem_w), 32'd1);
    w0 = mem_w_cnt; rsp0 = resp_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw.mem_w_drop", 32'(mem_w), 32'd0);
    chk("rstw.req_ready",  32'(req_ready), 32'd0);
    chk("rstw.state",      32'(dbg_state), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstw.ready_rel", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rstw.no_write", mem_w_cnt - w0, 32'd0);
    chk("rstw.no_resp",  resp_cnt - rsp0, 32'd0);
    chk("rstw.mem20",    tb_mem[8], 32'hCAFE_F00D);

    // back-to-back word stores with req_valid held high
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = bb_addr[0]; req_wdata = bb_data[0]; req_valid = 1'b1;
    w0 = mem_w_cnt;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (c > 0) @(negedge clk);
      rdy = req_ready;
      if (dbg_state != 2'd0) chk("b2b.ready_low", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      if (rdy) begin
        acc[n] = c;
        n++;
        if (n < 3) begin
          req_addr  = bb_addr[n];
          req_wdata = bb_data[n];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b2b.accepts", n, 32'd3);
    if (n == 3) begin
      chk("b2b.gap01", acc[1] - acc[0], 32'd3);
      chk("b2b.gap12", acc[2] - acc[1], 32'd3);
    end
    chk("b2b.writes", mem_w_cnt - w0, 32'd3);
    chk("b2b.mem30", tb_mem[12], 32'h0101_0101);
    chk("b2b.mem34", tb_mem[13], 32'h0202_0202);
    chk("b2b.mem38", tb_mem[14], 32'h0303_0303);
    chk("b2b.idle", 32'(dbg_state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
